vec_mem_dispatch: RTL and testbench
===================================

// Module: vec_mem_dispatch
// PURPOSE
//  Sits directly downstream of the Wishbone-to-stream converter. Consumes its instruction
//  and load/address streams, writes VLOAD data into the vector register file (VRF), and
//  reads the VRF for VSTORE, returning the word on the store stream. Forwards all other
//  opcodes to the execute stage through a registered single-entry output.
// PARAMETERS
//  DATA_W     32  element width, bits
//  NUM_ELEMS  32  VRF depth, elements
//  IDX_W      $clog2(NUM_ELEMS)  VRF address width
// PORTS
//  wb_clk_i              in   1   clock
//  wb_rst_n_i            in   1   reset, asynchronous assert, active-low
//  instruction_recv_msg  in   32  instr; [31:27] opcode
//  instruction_recv_val  in   1   instr valid
//  instruction_recv_rdy  out  1   instr ready
//  load_recv_msg         in   64  [63:32] element index, [31:0] data
//  load_recv_val         in   1   load/address beat valid
//  load_recv_rdy         out  1   load/address beat ready
//  store_send_msg        out  32  store data word
//  store_send_val        out  1   store data valid
//  store_send_rdy        in   1   store data ready
//  exec_instr_msg        out  32  non-memory instruction to execute stage
//  exec_instr_val        out  1   exec valid
//  exec_instr_rdy        in   1   exec ready
//  vrf_wen               out  1   VRF write enable
//  vrf_waddr / vrf_wdata out  IDX_W / DATA_W   VRF write port
//  vrf_ren               out  1   VRF read enable
//  vrf_raddr             out  IDX_W   VRF read address
//  vrf_rdata             in   DATA_W  VRF read data, valid 1 cycle after vrf_ren
//  idx_err_o             out  1   sticky: out-of-range index seen
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; all val/en outputs 0, msg/addr/data regs 0, idx_err_o 0.
//  - Opcode: 5'b00000 VLOAD, 5'b00001 VSTORE (memory ops); anything else is compute.
//  - Memory op fires only when instr val AND load val are both high in IDLE; both rdys go
//    high in that same cycle (paired consume). Memory instr with load_recv_val=0 -> instr_rdy=0.
//  - Compute op: instr_rdy = (state==IDLE) && (!exec_instr_val || exec_instr_rdy); load_rdy=0.
//    Captured into exec reg next edge; exec_instr_val held, msg stable, until exec_instr_rdy.
//  - Index check: idx=load_recv_msg[63:32]; idx >= NUM_ELEMS -> beat consumed, no VRF access,
//    idx_err_o set (sticky until reset); a VSTORE still returns 32'h0 on store stream.
//  - VLOAD (fire at T): T+1 vrf_wen=1 for one cycle, waddr=idx[IDX_W-1:0], wdata=data.
//    State stays IDLE; back-to-back VLOADs at 1/cycle.
//  - VSTORE FSM: IDLE -fire-> RD (vrf_ren=1, raddr=idx) -> CAP (capture vrf_rdata)
//    -> RSP (store_send_val=1, msg held) -store_send_rdy-> IDLE. Min latency fire->val = 3 cycles.
//    In RD/CAP/RSP both recv rdys are 0. Out-of-range store skips RD/CAP: IDLE -> RSP with msg 0.
//  - RAW: a VLOAD fired at T writes at T+1; a VSTORE fired at T+1 reads at T+2, so it sees
//    the new value with no bypass.
//  - Exec handoff: the exec reg may still hold a pending compute while memory ops proceed;
//    there is no ordering check between the two.
//  - store_send_rdy held high on RSP entry -> transfer on first RSP cycle, IDLE next.
// STRUCTURE
//  - Shared package vec_pkg: opcode localparams (OP_VLOAD, OP_VSTORE), opcode field slice
//    [31:27], FSM state enum {IDLE, RD, CAP, RSP}.
//  - Single module. The exec output register is inline; there is no sub-module.
// TESTING
//  1 VLOAD idx=3 data=32'hA5A5_0001 -> T+1 vrf_wen=1, waddr=3, wdata=A5A5_0001; idx_err_o=0.
//  2 VLOAD idx=7 data=0x1234, then VSTORE idx=7 next cycle -> store_send_msg=0x1234 three
//    cycles after store fire.
//  3 VSTORE idx=2, store_send_rdy low 5 cycles -> val/msg stable; all recv rdys 0 until rdy.
//  4 Compute instr 32'h2000_0042, exec_instr_rdy=0 -> exec_val held; a 2nd compute is
//    stalled (instr_rdy=0); a concurrent VLOAD still completes.
//  5 VLOAD idx=40 (NUM_ELEMS=32) -> no vrf_wen, idx_err_o=1; VSTORE idx=40 -> msg 0.
//  6 Assert wb_rst_n_i=0 during RSP -> outputs 0 immediately; IDLE after release; VLOAD works.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared definitions for the vector memory dispatch path: opcodes, opcode field, FSM states.
package vec_pkg;

    localparam logic [4:0] OP_VLOAD  = 5'b00000;
    localparam logic [4:0] OP_VSTORE = 5'b00001;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        CAP,
        RSP
    } state_t;

    function automatic logic [4:0] get_opcode(input logic [31:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/vec_mem_dispatch.sv
// Pairs instr+load beats: VLOAD writes the VRF 1 cycle later, VSTORE returns the word 3 cycles later.
// Compute ops go to a single-entry exec register; both recv streams stall while a store is in flight.
module vec_mem_dispatch
    import vec_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_ELEMS = 32,
    parameter int IDX_W     = $clog2(NUM_ELEMS)
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic [31:0]       instruction_recv_msg,
    input  logic              instruction_recv_val,
    output logic              instruction_recv_rdy,
    input  logic [63:0]       load_recv_msg,
    input  logic              load_recv_val,
    output logic              load_recv_rdy,
    output logic [DATA_W-1:0] store_send_msg,
    output logic              store_send_val,
    input  logic              store_send_rdy,
    output logic [31:0]       exec_instr_msg,
    output logic              exec_instr_val,
    input  logic              exec_instr_rdy,
    output logic              vrf_wen,
    output logic [IDX_W-1:0]  vrf_waddr,
    output logic [DATA_W-1:0] vrf_wdata,
    output logic              vrf_ren,
    output logic [IDX_W-1:0]  vrf_raddr,
    input  logic [DATA_W-1:0] vrf_rdata,
    output logic              idx_err_o
);

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_vrf_wen;
    logic [IDX_W-1:0]   r_vrf_waddr;
    logic [DATA_W-1:0]  r_vrf_wdata;
    logic               r_vrf_ren;
    logic [IDX_W-1:0]   r_vrf_raddr;
    logic [DATA_W-1:0]  r_store_msg;
    logic               r_exec_val;
    logic [31:0]        r_exec_msg;
    logic               r_idx_err;

    logic [4:0]         w_opcode;
    logic               w_is_load;
    logic               w_is_store;
    logic               w_is_mem;
    logic [31:0]        w_idx;
    logic               w_oor;
    logic               w_idle;
    logic               w_exec_free;
    logic               w_mem_fire;
    logic               w_cmp_fire;
    logic               w_store_val;

    assign w_opcode    = get_opcode(instruction_recv_msg);
    assign w_is_load   = (w_opcode == OP_VLOAD);
    assign w_is_store  = (w_opcode == OP_VSTORE);
    assign w_is_mem    = w_is_load || w_is_store;
    assign w_idx       = load_recv_msg[63:32];
    assign w_oor       = (w_idx >= 32'(NUM_ELEMS));
    assign w_idle      = (r_state == IDLE);
    assign w_exec_free = !r_exec_val || exec_instr_rdy;

    // Memory ops consume the instruction and its load/address beat together.
    assign w_mem_fire = w_idle && instruction_recv_val && load_recv_val && w_is_mem;
    assign w_cmp_fire = w_idle && instruction_recv_val && !w_is_mem && w_exec_free;

    assign instruction_recv_rdy = w_idle && (w_is_mem ? load_recv_val : w_exec_free);
    assign load_recv_rdy        = w_idle && instruction_recv_val && w_is_mem;

    always_comb begin
        w_state_nxt = r_state;
        w_store_val = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_mem_fire && w_is_store) begin
                    w_state_nxt = w_oor ? RSP : RD;
                end
            end
            RD:  w_state_nxt = CAP;
            CAP: w_state_nxt = RSP;
            RSP: begin
                w_store_val = 1'b1;
                if (store_send_rdy) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_vrf_wen   <= 1'b0;
            r_vrf_waddr <= '0;
            r_vrf_wdata <= '0;
            r_vrf_ren   <= 1'b0;
            r_vrf_raddr <= '0;
            r_store_msg <= '0;
            r_idx_err   <= 1'b0;
        end else begin
            r_vrf_wen <= w_mem_fire && w_is_load && !w_oor;
            r_vrf_ren <= w_mem_fire && w_is_store && !w_oor;
            if (w_mem_fire && !w_oor) begin
                if (w_is_load) begin
                    r_vrf_waddr <= w_idx[IDX_W-1:0];
                    r_vrf_wdata <= load_recv_msg[DATA_W-1:0];
                end else begin
                    r_vrf_raddr <= w_idx[IDX_W-1:0];
                end
            end
            if (w_mem_fire && w_oor) begin
                r_idx_err <= 1'b1;
            end
            // Out-of-range stores still answer, with a zero word.
            if (w_mem_fire && w_is_store && w_oor) begin
                r_store_msg <= '0;
            end else if (r_state == CAP) begin
                r_store_msg <= vrf_rdata;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_exec_val <= 1'b0;
            r_exec_msg <= '0;
        end else if (w_cmp_fire) begin
            r_exec_val <= 1'b1;
            r_exec_msg <= instruction_recv_msg;
        end else if (exec_instr_rdy) begin
            r_exec_val <= 1'b0;
        end
    end

    assign vrf_wen        = r_vrf_wen;
    assign vrf_waddr      = r_vrf_waddr;
    assign vrf_wdata      = r_vrf_wdata;
    assign vrf_ren        = r_vrf_ren;
    assign vrf_raddr      = r_vrf_raddr;
    assign store_send_msg = r_store_msg;
    assign store_send_val = w_store_val;
    assign exec_instr_msg = r_exec_msg;
    assign exec_instr_val = r_exec_val;
    assign idx_err_o      = r_idx_err;

endmodule

// File: tb/tb_vec_mem_dispatch.sv
// Directed bench for vec_mem_dispatch with a behavioural VRF (1-cycle registered read).
module tb_vec_mem_dispatch;

    localparam int DATA_W    = 32;
    localparam int NUM_ELEMS = 32;
    localparam int IDX_W     = 5;

    localparam logic [31:0] LD = 32'h0000_0011;
    localparam logic [31:0] ST = 32'h0800_0022;

    logic              clk;
    logic              rst_n;
    logic [31:0]       instr_msg;
    logic              instr_val;
    logic              instr_rdy;
    logic [63:0]       load_msg;
    logic              load_val;
    logic              load_rdy;
    logic [DATA_W-1:0] store_msg;
    logic              store_val;
    logic              store_rdy;
    logic [31:0]       exec_msg;
    logic              exec_val;
    logic              exec_rdy;
    logic              vrf_wen;
    logic [IDX_W-1:0]  vrf_waddr;
    logic [DATA_W-1:0] vrf_wdata;
    logic              vrf_ren;
    logic [IDX_W-1:0]  vrf_raddr;
    logic [DATA_W-1:0] vrf_rdata;
    logic              idx_err;

    logic [DATA_W-1:0] mem [0:NUM_ELEMS-1];

    int errors = 0;
    int checks = 0;

    vec_mem_dispatch #(
        .DATA_W    (DATA_W),
        .NUM_ELEMS (NUM_ELEMS),
        .IDX_W     (IDX_W)
    ) u_dut (
        .wb_clk_i             (clk),
        .wb_rst_n_i           (rst_n),
        .instruction_recv_msg (instr_msg),
        .instruction_recv_val (instr_val),
        .instruction_recv_rdy (instr_rdy),
        .load_recv_msg        (load_msg),
        .load_recv_val        (load_val),
        .load_recv_rdy        (load_rdy),
        .store_send_msg       (store_msg),
        .store_send_val       (store_val),
        .store_send_rdy       (store_rdy),
        .exec_instr_msg       (exec_msg),
        .exec_instr_val       (exec_val),
        .exec_instr_rdy       (exec_rdy),
        .vrf_wen              (vrf_wen),
        .vrf_waddr            (vrf_waddr),
        .vrf_wdata            (vrf_wdata),
        .vrf_ren              (vrf_ren),
        .vrf_raddr            (vrf_raddr),
        .vrf_rdata            (vrf_rdata),
        .idx_err_o            (idx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vrf_wen) mem[vrf_waddr] <= vrf_wdata;
        if (vrf_ren) vrf_rdata <= mem[vrf_raddr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive_mem(input logic [31:0] instr, input logic [31:0] idx, input logic [31:0] data);
        instr_msg = instr;
        instr_val = 1'b1;
        load_msg  = {idx, data};
        load_val  = 1'b1;
    endtask

    task automatic idle_in();
        instr_val = 1'b0;
        load_val  = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        instr_msg = '0;
        instr_val = 1'b0;
        load_msg  = '0;
        load_val  = 1'b0;
        store_rdy = 1'b0;
        exec_rdy  = 1'b0;
        vrf_rdata = '0;

        #12;
        check("rst_wen",       vrf_wen,   0);
        check("rst_ren",       vrf_ren,   0);
        check("rst_store_val", store_val, 0);
        check("rst_store_msg", store_msg, 0);
        check("rst_exec_val",  exec_val,  0);
        check("rst_exec_msg",  exec_msg,  0);
        check("rst_idx_err",   idx_err,   0);
        check("rst_waddr",     vrf_waddr, 0);
        check("rst_wdata",     vrf_wdata, 0);
        step();
        rst_n = 1'b1;

        // VLOAD idx 3
        step(); drive_mem(LD, 32'd3, 32'hA5A5_0001); settle();
        check("t1_instr_rdy", instr_rdy, 1);
        check("t1_load_rdy",  load_rdy,  1);
        step(); idle_in(); settle();
        check("t1_wen",     vrf_wen,   1);
        check("t1_waddr",   vrf_waddr, 3);
        check("t1_wdata",   vrf_wdata, 32'hA5A5_0001);
        check("t1_idx_err", idx_err,   0);
        step(); settle();
        check("t1_wen_pulse", vrf_wen, 0);

        // VLOAD idx 7 then VSTORE idx 7 back to back
        step(); drive_mem(LD, 32'd7, 32'h0000_1234); settle();
        step(); drive_mem(ST, 32'd7, 32'h0); settle();
        check("t2_st_instr_rdy", instr_rdy, 1);
        check("t2_st_load_rdy",  load_rdy,  1);
        check("t2_wen",          vrf_wen,   1);
        check("t2_waddr",        vrf_waddr, 7);
        step(); idle_in(); settle();
        check("t2_ren",       vrf_ren,   1);
        check("t2_raddr",     vrf_raddr, 7);
        check("t2_val_rd",    store_val, 0);
        step(); settle();
        check("t2_val_cap",   store_val, 0);
        step(); store_rdy = 1'b1; settle();
        check("t2_val_rsp",   store_val, 1);
        check("t2_msg",       store_msg, 32'h0000_1234);
        step(); store_rdy = 1'b0; settle();
        check("t2_val_done",  store_val, 0);

        // VSTORE idx 2 held off by store_send_rdy
        step(); drive_mem(LD, 32'd2, 32'hBEEF_0002); settle();
        step(); drive_mem(ST, 32'd2, 32'h0); settle();
        check("t3_st_rdy", instr_rdy, 1);
        step(); drive_mem(LD, 32'd9, 32'h0000_9999); settle();
        check("t3_rd_instr_rdy", instr_rdy, 0);
        check("t3_rd_load_rdy",  load_rdy,  0);
        step(); settle();
        check("t3_cap_load_rdy", load_rdy, 0);
        for (int i = 0; i < 5; i++) begin
            step(); settle();
            check("t3_hold_val",       store_val, 1);
            check("t3_hold_msg",       store_msg, 32'hBEEF_0002);
            check("t3_hold_instr_rdy", instr_rdy, 0);
            check("t3_hold_load_rdy",  load_rdy,  0);
        end
        step(); idle_in(); store_rdy = 1'b1; settle();
        check("t3_xfer_val", store_val, 1);
        check("t3_xfer_msg", store_msg, 32'hBEEF_0002);
        step(); store_rdy = 1'b0; settle();
        check("t3_done_val", store_val, 0);

        // Compute stalled at exec while a VLOAD proceeds
        step(); instr_msg = 32'h2000_0042; instr_val = 1'b1; load_val = 1'b0; settle();
        check("t4_cmp_rdy",      instr_rdy, 1);
        check("t4_cmp_load_rdy", load_rdy,  0);
        step(); instr_msg = 32'h2800_0055; settle();
        check("t4_exec_val",    exec_val,  1);
        check("t4_exec_msg",    exec_msg,  32'h2000_0042);
        check("t4_stall_rdy",   instr_rdy, 0);
        step(); drive_mem(LD, 32'd5, 32'h0000_55AA); settle();
        check("t4_hold_val",    exec_val,  1);
        check("t4_hold_msg",    exec_msg,  32'h2000_0042);
        check("t4_ld_instr_rdy", instr_rdy, 1);
        check("t4_ld_load_rdy",  load_rdy,  1);
        step(); instr_msg = 32'h2800_0055; load_val = 1'b0; exec_rdy = 1'b1; settle();
        check("t4_wen",         vrf_wen,   1);
        check("t4_waddr",       vrf_waddr, 5);
        check("t4_wdata",       vrf_wdata, 32'h0000_55AA);
        check("t4_still_val",   exec_val,  1);
        check("t4_still_msg",   exec_msg,  32'h2000_0042);
        check("t4_drain_rdy",   instr_rdy, 1);
        step(); idle_in(); settle();
        check("t4_exec2_val",   exec_val,  1);
        check("t4_exec2_msg",   exec_msg,  32'h2800_0055);
        step(); exec_rdy = 1'b0; settle();
        check("t4_exec_empty",  exec_val,  0);

        // Out-of-range index
        step(); drive_mem(LD, 32'd40, 32'h0000_DEAD); settle();
        check("t5_ld_rdy", load_rdy, 1);
        step(); drive_mem(ST, 32'd40, 32'h0); settle();
        check("t5_no_wen",   vrf_wen,   0);
        check("t5_idx_err",  idx_err,   1);
        check("t5_st_rdy",   instr_rdy, 1);
        step(); idle_in(); store_rdy = 1'b1; settle();
        check("t5_val",      store_val, 1);
        check("t5_msg_zero", store_msg, 0);
        check("t5_no_ren",   vrf_ren,   0);
        step(); store_rdy = 1'b0; settle();
        check("t5_done_val", store_val, 0);
        check("t5_sticky",   idx_err,   1);

        // Asynchronous reset during RSP
        step(); drive_mem(ST, 32'd7, 32'h0); settle();
        step(); idle_in();
        step();
        step(); settle();
        check("t6_pre_val", store_val, 1);
        check("t6_pre_msg", store_msg, 32'h0000_1234);
        rst_n = 1'b0;
        #1;
        check("t6_rst_val",     store_val, 0);
        check("t6_rst_msg",     store_msg, 0);
        check("t6_rst_idx_err", idx_err,   0);
        check("t6_rst_ren",     vrf_ren,   0);
        step();
        step();
        rst_n = 1'b1;
        step(); drive_mem(LD, 32'd1, 32'h0000_0BAD); settle();
        check("t6_ld_instr_rdy", instr_rdy, 1);
        check("t6_ld_load_rdy",  load_rdy,  1);
        step(); idle_in(); settle();
        check("t6_wen",   vrf_wen,   1);
        check("t6_waddr", vrf_waddr, 1);
        check("t6_wdata", vrf_wdata, 32'h0000_0BAD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
